// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller states and phase-selection helpers for the
// multi-phase intersection controller.
package traffic_pkg;

  localparam logic [2:0] LAMP_GREEN       = 3'b000;
  localparam logic [2:0] LAMP_FLASH_GREEN = 3'b001;
  localparam logic [2:0] LAMP_YELLOW      = 3'b011;
  localparam logic [2:0] LAMP_RED         = 3'b010;
  localparam logic [2:0] LAMP_FLASH_RED   = 3'b110;

  localparam int MAX_PHASES = 8;

  typedef enum logic [2:0] {
    ST_ALL_RED     = 3'd0,
    ST_GREEN       = 3'd1,
    ST_FLASH_GREEN = 3'd2,
    ST_YELLOW      = 3'd3,
    ST_NIGHT       = 3'd4
  } state_t;

  // First pending phase after cur (wrapping mod n); cur+1 when nothing is pending.
  function automatic int rr_next(input logic [MAX_PHASES-1:0] pend, input int cur, input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = (cur + 1) % n;
    found = 1'b0;
    for (int i = 1; i <= MAX_PHASES; i++) begin
      if (i <= n) begin
        idx = (cur + i) % n;
        if (!found && pend[idx[2:0]]) begin
          pick  = idx;
          found = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] lamp_of(input state_t st, input logic is_active);
    logic [2:0] lamp;
    lamp = LAMP_RED;
    case (st)
      ST_NIGHT:       lamp = LAMP_FLASH_RED;
      ST_GREEN:       lamp = is_active ? LAMP_GREEN : LAMP_RED;
      ST_FLASH_GREEN: lamp = is_active ? LAMP_FLASH_GREEN : LAMP_RED;
      ST_YELLOW:      lamp = is_active ? LAMP_YELLOW : LAMP_RED;
      ST_ALL_RED:     lamp = LAMP_RED;
      default:        lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Interval timer: counts cycles spent in the current controller state,
// saturating at all-ones so a long NIGHT interval never wraps.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Cycle counter, restarted on every state change
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r != {CNT_W{1'b1}}) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/traffic_controller.sv
// Multi-phase intersection controller: demand-driven green with min/max,
// flashing green, yellow and all-red clearance, round-robin service, night flash.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES    = 2,
  parameter int CNT_W         = 8,
  parameter int GREEN_MIN     = 20,
  parameter int GREEN_MAX     = 60,
  parameter int FLASH_CYCLES  = 4,
  parameter int YELLOW_CYCLES = 6,
  parameter int ALLRED_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [NUM_PHASES-1:0]         req,
  input  logic                          night_mode,
  output logic [3*NUM_PHASES-1:0]       light,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [NUM_PHASES-1:0]         req_pending
);

  localparam int PH_W = $clog2(NUM_PHASES);

  // Timer value on the last cycle of each interval
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [CNT_W-1:0]        count_s;
  logic                    timer_clear_s;
  logic [PH_W-1:0]         active_r;
  logic [PH_W-1:0]         active_next_s;
  logic [PH_W-1:0]         rr_pick_s;
  logic [NUM_PHASES-1:0]   pending_r;
  logic [NUM_PHASES-1:0]   pending_next_s;
  logic [NUM_PHASES-1:0]   active_oh_s;
  logic [NUM_PHASES-1:0]   next_oh_s;
  logic [MAX_PHASES-1:0]   pend8_s;
  logic                    other_demand_s;
  logic                    force_zero_r;
  logic                    force_zero_next_s;
  logic [3*NUM_PHASES-1:0] light_r;
  logic [3*NUM_PHASES-1:0] light_next_s;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rstb  (rstb),
    .clear (timer_clear_s),
    .count (count_s)
  );

  // Decode of the served phase, competing demand and the round-robin candidate
  always_comb begin
    active_oh_s = {NUM_PHASES{1'b0}};
    pend8_s     = {MAX_PHASES{1'b0}};
    for (int k = 0; k < NUM_PHASES; k++) begin
      active_oh_s[k] = (active_r == PH_W'(k));
      pend8_s[k]     = pending_r[k];
    end
    // A request arriving on the last minimum-green cycle still ends green on time
    other_demand_s = |((pending_r | req) & ~active_oh_s);
    rr_pick_s      = PH_W'(rr_next(pend8_s, int'(active_r), NUM_PHASES));
  end

  // Next-state and next-phase selection
  always_comb begin
    state_next_s      = state_r;
    active_next_s     = active_r;
    force_zero_next_s = force_zero_r;
    case (state_r)
      ST_ALL_RED: begin
        if (count_s >= ALLRED_LAST) begin
          if (night_mode) begin
            state_next_s = ST_NIGHT;
          end else begin
            state_next_s      = ST_GREEN;
            active_next_s     = force_zero_r ? {PH_W{1'b0}} : rr_pick_s;
            force_zero_next_s = 1'b0;
          end
        end else begin
          state_next_s = ST_ALL_RED;
        end
      end
      ST_GREEN: begin
        if ((count_s >= GMAX_LAST) || ((count_s >= GMIN_LAST) && other_demand_s)) begin
          state_next_s = ST_FLASH_GREEN;
        end else begin
          state_next_s = ST_GREEN;
        end
      end
      ST_FLASH_GREEN: begin
        if (count_s >= FLASH_LAST) begin
          state_next_s = ST_YELLOW;
        end else begin
          state_next_s = ST_FLASH_GREEN;
        end
      end
      ST_YELLOW: begin
        if (count_s >= YELLOW_LAST) begin
          state_next_s = ST_ALL_RED;
        end else begin
          state_next_s = ST_YELLOW;
        end
      end
      ST_NIGHT: begin
        if (!night_mode) begin
          state_next_s      = ST_ALL_RED;
          force_zero_next_s = 1'b1;
        end else begin
          state_next_s = ST_NIGHT;
        end
      end
      default: begin
        state_next_s = ST_ALL_RED;
      end
    endcase
  end

  assign timer_clear_s = (state_next_s != state_r);

  // Request latch: set on demand, consumed on green entry, flushed by night mode
  always_comb begin
    next_oh_s = {NUM_PHASES{1'b0}};
    for (int k = 0; k < NUM_PHASES; k++) begin
      next_oh_s[k] = (active_next_s == PH_W'(k));
    end
    if ((state_r == ST_NIGHT) || (state_next_s == ST_NIGHT)) begin
      pending_next_s = {NUM_PHASES{1'b0}};
    end else if (state_r == ST_GREEN) begin
      pending_next_s = pending_r | (req & ~active_oh_s);
    end else if (state_next_s == ST_GREEN) begin
      pending_next_s = (pending_r | req) & ~next_oh_s;
    end else begin
      pending_next_s = pending_r | req;
    end
  end

  // Lamp codes for the state being entered, so light is valid on entry
  always_comb begin
    light_next_s = {NUM_PHASES{LAMP_RED}};
    for (int k = 0; k < NUM_PHASES; k++) begin
      light_next_s[3*k +: 3] = lamp_of(state_next_s, active_next_s == PH_W'(k));
    end
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r      <= ST_ALL_RED;
      active_r     <= PH_W'(NUM_PHASES - 1);
      pending_r    <= {NUM_PHASES{1'b0}};
      force_zero_r <= 1'b0;
      light_r      <= {NUM_PHASES{LAMP_RED}};
    end else begin
      state_r      <= state_next_s;
      active_r     <= active_next_s;
      pending_r    <= pending_next_s;
      force_zero_r <= force_zero_next_s;
      light_r      <= light_next_s;
    end
  end

  assign light        = light_r;
  assign active_phase = active_r;
  assign req_pending  = pending_r;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller: a 2-phase instance for sequencing,
// night and reset scenarios, and a 4-phase instance for round-robin wrap.
module tb_traffic_controller;

  logic        clk;
  logic        rstb;
  logic [1:0]  req;
  logic        night_mode;
  logic [5:0]  light;
  logic [0:0]  active_phase;
  logic [1:0]  req_pending;

  logic        rstb4;
  logic [3:0]  req4;
  logic        night4;
  logic [11:0] light4;
  logic [1:0]  active4;
  logic [3:0]  pending4;

  int checks;
  int passes;

  traffic_controller #(.NUM_PHASES(2)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .req          (req),
    .night_mode   (night_mode),
    .light        (light),
    .active_phase (active_phase),
    .req_pending  (req_pending)
  );

  traffic_controller #(.NUM_PHASES(4)) dut4 (
    .clk          (clk),
    .rstb         (rstb4),
    .req          (req4),
    .night_mode   (night4),
    .light        (light4),
    .active_phase (active4),
    .req_pending  (pending4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for two cycles and release on a falling edge
  task automatic do_reset();
    rstb       = 1'b0;
    req        = 2'b00;
    night_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (light !== 6'o22) $display("FAIL reset_light: got %o want %o", light, 6'o22); else passes++;
    checks++; if (active_phase !== 1'b1) $display("FAIL reset_active: got %0d want 1", active_phase); else passes++;
    checks++; if (req_pending !== 2'b00) $display("FAIL reset_pending: got %b want 00", req_pending); else passes++;
    checks++; if (light4 !== 12'o2222) $display("FAIL reset_light4: got %o want %o", light4, 12'o2222); else passes++;
    checks++; if (active4 !== 2'd3) $display("FAIL reset_active4: got %0d want 3", active4); else passes++;
  endtask

  task automatic test_recall();
    int         lens[6];
    logic [5:0] exps[6];
    lens = '{2, 60, 4, 6, 3, 1};
    exps = '{6'o22, 6'o20, 6'o21, 6'o23, 6'o22, 6'o02};
    do_reset();
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < lens[s]; c++) begin
        @(negedge clk);
        checks++;
        if (light !== exps[s]) $display("FAIL recall_seg%0d_cyc%0d: got %o want %o", s, c, light, exps[s]);
        else passes++;
      end
    end
    checks++; if (active_phase !== 1'b1) $display("FAIL recall_active: got %0d want 1", active_phase); else passes++;
  endtask

  task automatic test_min_green();
    logic [5:0] exp_l;
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      exp_l = (k <= 2) ? 6'o22 : (k <= 22) ? 6'o20 : (k <= 26) ? 6'o21 :
              (k <= 32) ? 6'o23 : (k <= 35) ? 6'o22 : 6'o02;
      checks++;
      if (light !== exp_l) $display("FAIL min_green_k%0d: got %o want %o", k, light, exp_l);
      else passes++;
      if (k == 8) begin
        checks++; if (req_pending !== 2'b10) $display("FAIL min_green_latch: got %b want 10", req_pending); else passes++;
      end
      if (k == 36) begin
        checks++; if (req_pending !== 2'b00) $display("FAIL min_green_consume: got %b want 00", req_pending); else passes++;
        checks++; if (active_phase !== 1'b1) $display("FAIL min_green_active: got %0d want 1", active_phase); else passes++;
      end
      req = (k == 7) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic test_wrap4();
    rstb4 = 1'b0; req4 = 4'b0000; night4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb4 = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      if (k == 22) begin
        checks++; if (light4 !== 12'o2220) $display("FAIL wrap_p0_last: got %o want %o", light4, 12'o2220); else passes++;
      end
      if (k == 23) begin
        checks++; if (light4 !== 12'o2221) $display("FAIL wrap_p0_flash: got %o want %o", light4, 12'o2221); else passes++;
      end
      if (k == 36) begin
        checks++; if (light4 !== 12'o2022) $display("FAIL wrap_p2_green: got %o want %o", light4, 12'o2022); else passes++;
        checks++; if (active4 !== 2'd2) $display("FAIL wrap_p2_active: got %0d want 2", active4); else passes++;
      end
      if (k == 41) begin
        checks++; if (pending4 !== 4'b0011) $display("FAIL wrap_pending: got %b want 0011", pending4); else passes++;
      end
      if (k == 68) begin
        checks++; if (light4 !== 12'o2222) $display("FAIL wrap_allred: got %o want %o", light4, 12'o2222); else passes++;
        checks++; if (active4 !== 2'd2) $display("FAIL wrap_recent: got %0d want 2", active4); else passes++;
      end
      if (k == 69) begin
        checks++; if (light4 !== 12'o2220) $display("FAIL wrap_p0_green: got %o want %o", light4, 12'o2220); else passes++;
        checks++; if (active4 !== 2'd0) $display("FAIL wrap_to0: got %0d want 0", active4); else passes++;
        checks++; if (pending4 !== 4'b0010) $display("FAIL wrap_left: got %b want 0010", pending4); else passes++;
      end
      if (k == 102) begin
        checks++; if (light4 !== 12'o2202) $display("FAIL wrap_p1_green: got %o want %o", light4, 12'o2202); else passes++;
        checks++; if (active4 !== 2'd1) $display("FAIL wrap_to1: got %0d want 1", active4); else passes++;
        checks++; if (pending4 !== 4'b0000) $display("FAIL wrap_empty: got %b want 0000", pending4); else passes++;
      end
      req4 = (k == 4) ? 4'b0100 : (k == 40) ? 4'b0011 : 4'b0000;
    end
  endtask

  task automatic test_night();
    do_reset();
    for (int k = 1; k <= 84; k++) begin
      @(negedge clk);
      if (k == 62) begin
        checks++; if (light !== 6'o20) $display("FAIL night_green_kept: got %o want %o", light, 6'o20); else passes++;
      end
      if (k == 72) begin
        checks++; if (light !== 6'o23) $display("FAIL night_yellow_kept: got %o want %o", light, 6'o23); else passes++;
      end
      if (k == 75) begin
        checks++; if (light !== 6'o22) $display("FAIL night_allred: got %o want %o", light, 6'o22); else passes++;
      end
      if (k == 76 || k == 80) begin
        checks++; if (light !== 6'o66) $display("FAIL night_flash_k%0d: got %o want %o", k, light, 6'o66); else passes++;
      end
      if (k == 78) begin
        checks++; if (req_pending !== 2'b00) $display("FAIL night_ignore: got %b want 00", req_pending); else passes++;
      end
      if (k == 81 || k == 83) begin
        checks++; if (light !== 6'o22) $display("FAIL night_exit_k%0d: got %o want %o", k, light, 6'o22); else passes++;
      end
      if (k == 84) begin
        checks++; if (light !== 6'o20) $display("FAIL night_to_p0: got %o want %o", light, 6'o20); else passes++;
        checks++; if (active_phase !== 1'b0) $display("FAIL night_active: got %0d want 0", active_phase); else passes++;
        checks++; if (req_pending !== 2'b10) $display("FAIL night_post_req: got %b want 10", req_pending); else passes++;
      end
      if (k == 5) night_mode = 1'b1;
      if (k == 80) night_mode = 1'b0;
      req = (k == 77) ? 2'b11 : (k == 81) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic test_reset_mid_yellow();
    do_reset();
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      req = (k == 4) ? 2'b10 : 2'b00;
    end
    checks++; if (light !== 6'o23) $display("FAIL myel_in_yellow: got %o want %o", light, 6'o23); else passes++;
    checks++; if (req_pending !== 2'b10) $display("FAIL myel_pending_pre: got %b want 10", req_pending); else passes++;
    #2 rstb = 1'b0;
    #1;
    checks++; if (light !== 6'o22) $display("FAIL myel_async_light: got %o want %o", light, 6'o22); else passes++;
    checks++; if (req_pending !== 2'b00) $display("FAIL myel_async_pending: got %b want 00", req_pending); else passes++;
    checks++; if (active_phase !== 1'b1) $display("FAIL myel_async_active: got %0d want 1", active_phase); else passes++;
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (light !== ((k <= 2) ? 6'o22 : 6'o20)) $display("FAIL myel_restart_k%0d: got %o", k, light);
      else passes++;
    end
    checks++; if (active_phase !== 1'b0) $display("FAIL myel_restart_active: got %0d want 0", active_phase); else passes++;
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    rstb       = 1'b1;
    rstb4      = 1'b1;
    req        = 2'b00;
    req4       = 4'b0000;
    night_mode = 1'b0;
    night4     = 1'b0;
    #2;
    rstb  = 1'b0;
    rstb4 = 1'b0;
    test_reset();
    test_recall();
    test_min_green();
    test_wrap4();
    test_night();
    test_reset_mid_yellow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
